// File: rtl/audio_pkg.sv
// Shared definitions for the HDMI audio sample conditioner: FSM encoding and
// the per-channel rescale/saturate and volume-shift arithmetic.
package audio_pkg;

  localparam int unsigned ST_W       = 2;
  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_CAPTURE = 2'd1;
  localparam logic [1:0]  ST_PROC    = 2'd2;
  localparam logic [1:0]  ST_COMMIT  = 2'd3;

  localparam int unsigned CALC_W = 64;

  // Arithmetic right shift, then clamp into a signed out_width range.
  function automatic logic signed [CALC_W-1:0] sat_shift(
    input logic signed [CALC_W-1:0] x,
    input int unsigned              in_shift,
    input int unsigned              out_width
  );
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    s  = x >>> in_shift;
    hi = (CALC_W'(1) <<< (out_width - 1)) - CALC_W'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Level 0 mutes; the top level is unity; each step below halves the amplitude.
  function automatic logic signed [CALC_W-1:0] vol_scale(
    input logic signed [CALC_W-1:0] x,
    input int unsigned              level,
    input int unsigned              vol_bits
  );
    if (level == 0) return '0;
    return x >>> ((32'd1 << vol_bits) - 32'd1 - level);
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Fractional phase accumulator producing an exact-rate square wave and a
// one-cycle strobe on each rising edge.
module audio_tick_gen #(
  parameter int unsigned CLK_HZ  = 27000000,
  parameter int unsigned RATE_HZ = 48000
) (
  input  logic clk,
  input  logic resetn,
  output logic audio_clk,
  output logic tick
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ) + 1;
  localparam int unsigned STEP  = 2 * RATE_HZ;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic             wrap;
  logic             audio_clk_q, audio_clk_d;
  logic             tick_q, tick_d;

  // The remainder is carried across wraps, so the long-run rate never drifts.
  always_comb begin
    sum         = acc_q + ACC_W'(STEP);
    wrap        = (sum >= ACC_W'(CLK_HZ));
    acc_d       = wrap ? (sum - ACC_W'(CLK_HZ)) : sum;
    audio_clk_d = audio_clk_q ^ wrap;
    tick_d      = wrap & ~audio_clk_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q       <= '0;
      audio_clk_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      audio_clk_q <= audio_clk_d;
      tick_q      <= tick_d;
    end
  end

  assign audio_clk = audio_clk_q;
  assign tick      = tick_q;

endmodule

// File: rtl/audio_mixer.sv
// HDMI audio sample conditioner: snapshots all channels on each sample tick,
// rescales/saturates/attenuates them through one shared datapath, commits atomically.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned IN_SHIFT  = 2,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned VOL_BITS  = 2,
  parameter int unsigned CLK_HZ    = 27000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [CHANNELS*IN_WIDTH-1:0]  audio_in,
  input  logic [VOL_BITS-1:0]           volume,
  input  logic                          mute,
  output logic                          audio_clk,
  output logic [CHANNELS*OUT_WIDTH-1:0] audio_out,
  output logic                          sample_valid,
  output logic [VOL_BITS-1:0]           vol_level
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  if (CLK_HZ / (2 * SAMPLE_HZ) <= CHANNELS + 3) begin : g_rate_check
    $error("audio_mixer: CLK_HZ/(2*SAMPLE_HZ) must exceed CHANNELS+3");
  end

  logic tick;

  audio_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .RATE_HZ (SAMPLE_HZ)
  ) u_tick_gen (
    .clk       (clk),
    .resetn    (resetn),
    .audio_clk (audio_clk),
    .tick      (tick)
  );

  logic [ST_W-1:0]               state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [CHANNELS*IN_WIDTH-1:0]  snap_q, snap_d;
  logic [CHANNELS*OUT_WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*OUT_WIDTH-1:0] audio_out_q, audio_out_d;
  logic                          sample_valid_q, sample_valid_d;
  logic [VOL_BITS-1:0]           vol_level_q, vol_level_d;

  logic signed [IN_WIDTH-1:0]    cur_in;
  logic [OUT_WIDTH-1:0]          proc_out;
  logic [VOL_BITS-1:0]           vol_target;

  // Shared channel datapath, driven by the channel selected in PROC.
  always_comb begin
    cur_in = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == CH_W'(i)) cur_in = snap_q[i*IN_WIDTH +: IN_WIDTH];
    end
    proc_out   = OUT_WIDTH'(vol_scale(sat_shift(CALC_W'(cur_in), IN_SHIFT, OUT_WIDTH),
                                      32'(vol_level_q), VOL_BITS));
    vol_target = mute ? '0 : volume;
  end

  // Outputs and the new volume level land on the edge that enters COMMIT.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    snap_d         = snap_q;
    shadow_d       = shadow_q;
    audio_out_d    = audio_out_q;
    sample_valid_d = 1'b0;
    vol_level_d    = vol_level_q;

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        snap_d  = audio_in;
        ch_d    = '0;
        state_d = ST_PROC;
      end
      ST_PROC: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (ch_q == CH_W'(i)) shadow_d[i*OUT_WIDTH +: OUT_WIDTH] = proc_out;
        end
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d        = ST_COMMIT;
          audio_out_d    = shadow_d;
          sample_valid_d = 1'b1;
          if (vol_target > vol_level_q)      vol_level_d = vol_level_q + VOL_BITS'(1);
          else if (vol_target < vol_level_q) vol_level_d = vol_level_q - VOL_BITS'(1);
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      snap_q         <= '0;
      shadow_q       <= '0;
      audio_out_q    <= '0;
      sample_valid_q <= 1'b0;
      vol_level_q    <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      snap_q         <= snap_d;
      shadow_q       <= shadow_d;
      audio_out_q    <= audio_out_d;
      sample_valid_q <= sample_valid_d;
      vol_level_q    <= vol_level_d;
    end
  end

  assign audio_out    = audio_out_q;
  assign sample_valid = sample_valid_q;
  assign vol_level    = vol_level_q;

endmodule
